draw_crown: RTL and testbench

- Pixel-pipeline stage that overlays the 64x48 crown sprite onto the VGA stream.
- Reads the crown sprite ROM: generates the 12-bit ROM address from the beam position and consumes the ROM's 1-cycle-latency 12-bit rgb word.
- Delays all timing signals to stay aligned with the ROM data.
- Sits between the previous draw stage (background/player) and the next draw stage or the VGA output register.

---
 rtl/draw_crown.sv | 130 +++++++++++++
 tb/tb_draw_crown.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_crown.sv
// Crown sprite overlay stage: generates sprite ROM addresses from the beam position,
// composites the 1-cycle-latency ROM colour over the upstream pixel, 3-clk latency.
module draw_crown #(
  parameter int          WIDTH     = 64,
  parameter int          HEIGHT    = 48,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  timing_t     tim_in;
  timing_t     tim_d1_q, tim_d1_d, tim_d2_q, tim_d2_d, tim_out_q, tim_out_d;
  logic        vblnk_prev_q, vblnk_prev_d;
  logic [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        in_spr_d1_q, in_spr_d1_d, in_spr_d2_q, in_spr_d2_d;
  logic [11:0] rgb_d1_q, rgb_d1_d, rgb_d2_q, rgb_d2_d, rgb_out_q, rgb_out_d;
  logic [11:0] rom_addr_q, rom_addr_d;

  logic [11:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end, dh, dv;
  logic        in_spr;

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  // 12-bit compares so a window reaching past 2047 clips instead of wrapping
  always_comb begin
    h_ext  = {1'b0, hcount_in};
    v_ext  = {1'b0, vcount_in};
    x_ext  = {1'b0, xpos_q};
    y_ext  = {1'b0, ypos_q};
    x_end  = x_ext + 12'(WIDTH);
    y_end  = y_ext + 12'(HEIGHT);
    dh     = h_ext - x_ext;
    dv     = v_ext - y_ext;
    in_spr = enable & ~hblnk_in & ~vblnk_in &
             (h_ext >= x_ext) & (h_ext < x_end) &
             (v_ext >= y_ext) & (v_ext < y_end);
  end

  always_comb begin
    vblnk_prev_d = vblnk_in;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    if (vblnk_in && !vblnk_prev_q) begin
      xpos_d = xpos;
      ypos_d = ypos;
    end

    rom_addr_d  = in_spr ? (dv * 12'(WIDTH) + dh) : 12'h000;
    in_spr_d1_d = in_spr;
    tim_d1_d    = tim_in;
    rgb_d1_d    = rgb_in;

    in_spr_d2_d = in_spr_d1_q;
    tim_d2_d    = tim_d1_q;
    rgb_d2_d    = rgb_d1_q;

    tim_out_d   = tim_d2_q;
    rgb_out_d   = (in_spr_d2_q && (rom_rgb != KEY_COLOR)) ? rom_rgb : rgb_d2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      rom_addr_q   <= '0;
      in_spr_d1_q  <= 1'b0;
      in_spr_d2_q  <= 1'b0;
      tim_d1_q     <= '0;
      tim_d2_q     <= '0;
      tim_out_q    <= '0;
      rgb_d1_q     <= '0;
      rgb_d2_q     <= '0;
      rgb_out_q    <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      rom_addr_q   <= rom_addr_d;
      in_spr_d1_q  <= in_spr_d1_d;
      in_spr_d2_q  <= in_spr_d2_d;
      tim_d1_q     <= tim_d1_d;
      tim_d2_q     <= tim_d2_d;
      tim_out_q    <= tim_out_d;
      rgb_d1_q     <= rgb_d1_d;
      rgb_d2_q     <= rgb_d2_d;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = tim_out_q.hcount;
  assign vcount_out = tim_out_q.vcount;
  assign hsync_out  = tim_out_q.hsync;
  assign vsync_out  = tim_out_q.vsync;
  assign hblnk_out  = tim_out_q.hblnk;
  assign vblnk_out  = tim_out_q.vblnk;
  assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_draw_crown.sv
// Scoreboard bench for draw_crown: driver computes expected pixels from the sprite
// rules and queues them; a negedge monitor pops and compares when each comes due.
module tb_draw_crown;
  localparam int W = 64;
  localparam int H = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] xpos = '0, ypos = '0, hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_crown #(.WIDTH(W), .HEIGHT(H), .KEY_COLOR(12'h000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Sprite ROM contents: fixed entries at 5/6, scattered transparent words elsewhere
  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    if (a == 12'd5) return 12'hF80;
    if (a == 12'd6) return 12'h000;
    if (a % 12'd9 == 12'd0) return 12'h000;
    return a * 12'd37 + 12'd1;
  endfunction

  always @(posedge clk) rom_rgb <= rom_fn(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [11:0] addr; } aexp_t;
  typedef struct { int due; logic [37:0] v; } oexp_t;
  aexp_t aq[$];
  oexp_t oq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference state: position latched on each vblank rising edge
  int m_x = 0, m_y = 0;
  bit m_pvb = 1'b0;

  task automatic apply(input bit en, input int xp, input int yp, input int h, input int v,
                       input bit hs, input bit vs, input bit hb, input bit vb,
                       input logic [11:0] rgb);
    bit          spr;
    logic [11:0] addr;
    logic [11:0] col;
    aexp_t       ae;
    oexp_t       oe;
    @(posedge clk); #1;
    enable = en; xpos = xp[10:0]; ypos = yp[10:0];
    hcount_in = h[10:0]; vcount_in = v[10:0];
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    spr  = en && !hb && !vb && h >= m_x && h < m_x + W && v >= m_y && v < m_y + H;
    addr = spr ? 12'(((v - m_y) * W + (h - m_x)) % 4096) : 12'h000;
    col  = (spr && rom_fn(addr) != 12'h000) ? rom_fn(addr) : rgb;
    ae.due = cyc + 1; ae.addr = addr;
    oe.due = cyc + 3;
    oe.v   = {h[10:0], v[10:0], hs, vs, hb, vb, col};
    aq.push_back(ae);
    oq.push_back(oe);
    if (vb && !m_pvb) begin m_x = xp; m_y = yp; end
    m_pvb = vb;
  endtask

  task automatic pix(input bit en, input int h, input int v, input logic [11:0] rgb);
    apply(en, int'(xpos), int'(ypos), h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb);
  endtask

  task automatic vpulse(input int xp, input int yp);
    apply(1'b0, xp, yp, 0, 480, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    apply(1'b0, xp, yp, 0, 481, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0);
    apply(1'b0, xp, yp, 0, 482, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0);
    apply(1'b0, xp, yp, 0, 0,   1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
                hblnk_out, vblnk_out, rgb_out});
  endfunction

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    #1 chk("reset_async", all_outs(), 64'd0);
    aq.delete(); oq.delete();
    m_x = 0; m_y = 0; m_pvb = 1'b0;
    enable = 0; xpos = '0; ypos = '0; hcount_in = '0; vcount_in = '0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (aq.size() > 0 && aq[0].due <= cyc) begin
        if (aq[0].due < cyc) chk("rom_addr_due", 64'(cyc), 64'(aq[0].due));
        else chk("rom_addr", 64'(rom_addr), 64'(aq[0].addr));
        void'(aq.pop_front());
      end
      while (oq.size() > 0 && oq[0].due <= cyc) begin
        if (oq[0].due < cyc) chk("pixel_due", 64'(cyc), 64'(oq[0].due));
        else chk("pixel_out", 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                                   hblnk_out, vblnk_out, rgb_out}), 64'(oq[0].v));
        void'(oq.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_initial", all_outs(), 64'd0);
    @(negedge clk); rst = 1'b0;

    // First pixel after reset: latency 3
    apply(1'b0, 0, 0, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0AB);
    apply(1'b0, 0, 0, 6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AC);

    // Latch 100,200 and probe address corners / outside edges
    vpulse(100, 200);
    pix(1, 100, 200, 12'h123); pix(1, 163, 200, 12'h123);
    pix(1, 100, 201, 12'h123); pix(1, 163, 247, 12'h123);
    pix(1, 164, 200, 12'h123); pix(1, 100, 248, 12'h123);
    pix(1,  99, 200, 12'h123); pix(1, 100, 199, 12'h123);
    pix(1, 105, 200, 12'h123); pix(1, 106, 200, 12'h123);
    pix(1, 107, 200, 12'h123);
    // Blanking and enable inside window
    apply(1'b1, 100, 200, 110, 210, 1'b0, 1'b0, 1'b1, 1'b0, 12'h456);
    pix(0, 110, 210, 12'h789); pix(1, 110, 210, 12'h789); pix(0, 111, 210, 12'h78A);

    // Mid-frame position change has no effect until vblank
    pix(1, 120, 210, 12'h321);
    apply(1'b1, 300, 200, 121, 210, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
    pix(1, 300, 210, 12'h321); pix(1, 122, 211, 12'h321);
    vpulse(300, 200);
    pix(1, 300, 210, 12'h321); pix(1, 122, 211, 12'h321); pix(1, 363, 210, 12'h321);

    // Clipping at the right edge
    vpulse(2000, 10);
    pix(1, 2000, 10, 12'hABC); pix(1, 2047, 10, 12'hABC); pix(1, 2030, 57, 12'hABC);
    pix(1, 0, 10, 12'hABC); pix(1, 15, 10, 12'hABC); pix(1, 15, 20, 12'hABC);

    // Mid-line reset: latched position returns to 0,0
    pix(1, 2010, 20, 12'h111);
    do_reset();
    pix(1, 10, 10, 12'h222); pix(1, 63, 47, 12'h222); pix(1, 64, 10, 12'h222);
    pix(1, 2010, 20, 12'h222);

    // Randomized frames
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        int px = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1980, 2047))
                                               : int'($urandom_range(0, 1900)));
        vpulse(px, int'($urandom_range(0, 1100)));
      end else begin
        int h = m_x - 8 + int'($urandom_range(0, W + 16));
        int v = m_y - 4 + int'($urandom_range(0, H + 8));
        if ($urandom_range(0, 9) == 0) h = int'($urandom_range(0, 2047));
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        apply(($urandom_range(0, 7) != 0), int'(xpos) ^ int'($urandom_range(0, 3)), int'(ypos),
              h, v, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) == 0, 1'b0, 12'($urandom_range(0, 4095)));
      end
    end

    repeat (6) @(posedge clk);
    @(negedge clk);
    #1 chk("drain_empty", 64'(aq.size() + oq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
